prog_sync_delay: RTL and testbench

PROG_SYNC_DELAY -- requirements
Module: prog_sync_delay

---
 rtl/prog_sync_delay.sv | 96 +++++++++
 tb/tb_prog_sync_delay.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sync_delay.sv
// Programmable-latency delay line: every input sample reappears exactly cur_delay
// cycles later, with outputs held at zero until the line has refilled after reset or a load.
module prog_sync_delay #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 1,
  localparam int DLY_W        = $clog2(MAX_DELAY + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic [DLY_W-1:0]      delay,
  input  logic                  load_delay,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  primed,
  output logic [DLY_W-1:0]      cur_delay
);

  localparam int PTR_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int DEF_CLAMPED = (DEFAULT_DELAY < 1) ? 1 :
                               (DEFAULT_DELAY > MAX_DELAY) ? MAX_DELAY : DEFAULT_DELAY;
  localparam logic [DLY_W-1:0] DEF_DLY = DLY_W'(DEF_CLAMPED);

  function automatic logic [DLY_W-1:0] clamp_delay(input logic [DLY_W-1:0] d);
    if (d == '0)                  return DLY_W'(1);
    else if (int'(d) > MAX_DELAY) return DLY_W'(MAX_DELAY);
    else                          return d;
  endfunction

  logic [DATA_WIDTH:0] mem [MAX_DELAY];
  logic [PTR_W-1:0]    wp;
  logic [PTR_W-1:0]    rd_ptr;
  logic [DLY_W-1:0]    fill;
  logic [DATA_WIDTH:0] rd_word;
  int                  rd_diff;

  // Sample k lives D slots behind the write pointer at edge k+D; when D equals
  // MAX_DELAY the read slot is the one being overwritten, so the old word is read.
  always_comb begin
    rd_diff = int'(wp) - int'(cur_delay);
    rd_ptr  = '0;
    if (rd_diff < 0) rd_ptr = PTR_W'(rd_diff + MAX_DELAY);
    else             rd_ptr = PTR_W'(rd_diff);
  end

  assign rd_word = mem[rd_ptr];

  // NOTE: the sample memory has no reset; stale contents are never visible because
  // the outputs stay gated until the fill counter has seen cur_delay fresh samples.
  always_ff @(posedge clk) begin
    if (!rst) mem[wp] <= {din_valid, din};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
    end else if (wp == PTR_W'(MAX_DELAY - 1)) begin
      wp <= '0;
    end else begin
      wp <= wp + PTR_W'(1);
    end
  end

  // fill counts samples held in the current regime; the load edge's own sample is the first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_delay  <= DEF_DLY;
      fill       <= '0;
      primed     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (load_delay) begin
      cur_delay  <= clamp_delay(delay);
      fill       <= DLY_W'(1);
      primed     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (fill != cur_delay) fill <= fill + DLY_W'(1);
      if (fill == cur_delay) begin
        primed     <= 1'b1;
        dout       <= rd_word[DATA_WIDTH-1:0];
        dout_valid <= rd_word[DATA_WIDTH];
      end else begin
        primed     <= 1'b0;
        dout       <= '0;
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prog_sync_delay.sv
// Directed bench for prog_sync_delay: reset, default delay, wrap at D=16,
// reload, clamping, valid bubbles and asynchronous mid-stream reset.
module tb_prog_sync_delay;

  localparam int DW    = 32;
  localparam int MD    = 16;
  localparam int DLY_W = $clog2(MD + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    din;
  logic             din_valid;
  logic [DLY_W-1:0] delay;
  logic             load_delay;
  logic [DW-1:0]    dout;
  logic             dout_valid;
  logic             primed;
  logic [DLY_W-1:0] cur_delay;

  int vectors     = 0;
  int miscompares = 0;

  prog_sync_delay #(.DATA_WIDTH(DW), .MAX_DELAY(MD), .DEFAULT_DELAY(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .delay      (delay),
    .load_delay (load_delay),
    .dout       (dout),
    .dout_valid (dout_valid),
    .primed     (primed),
    .cur_delay  (cur_delay)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = '0; din_valid = 1'b0; delay = '0; load_delay = 1'b0;
    #1;
    vectors++;
    if (dout !== '0 || dout_valid !== 1'b0 || primed !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: dout=%0d dv=%b primed=%b, expected 0/0/0", dout, dout_valid, primed);
    end
    vectors++;
    if (cur_delay !== DLY_W'(1)) begin
      miscompares++;
      $display("FAIL reset_cur_delay: got %0d expected 1", cur_delay);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Default delay 1: din 1,2,3... ; first edge unprimed, then dout = din one cycle late.
  task automatic test_default();
    for (int i = 1; i <= 8; i++) begin
      din = DW'(i); din_valid = 1'b1;
      tick();
      vectors++;
      if (i == 1) begin
        if (primed !== 1'b0 || dout !== '0 || dout_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL default_fill: primed=%b dout=%0d expected 0/0", primed, dout);
        end
      end else if (primed !== 1'b1 || dout !== DW'(i - 1) || dout_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL default_d1 i=%0d: dout=%0d primed=%b expected %0d/1", i, dout, primed, i - 1);
      end
    end
  endtask

  // D=16 with a long ramp so the write pointer wraps twice while primed.
  task automatic test_wrap();
    for (int j = 0; j < 56; j++) begin
      load_delay = (j == 0); delay = DLY_W'(16);
      din = DW'(1000 + j); din_valid = 1'b1;
      tick();
      vectors++;
      if (j < 16) begin
        if (primed !== 1'b0 || dout !== '0) begin
          miscompares++;
          $display("FAIL wrap_fill j=%0d: dout=%0d primed=%b expected 0/0", j, dout, primed);
        end
      end else if (primed !== 1'b1 || dout !== DW'(1000 + j - 16)) begin
        miscompares++;
        $display("FAIL wrap_data j=%0d: dout=%0d primed=%b expected %0d/1", j, dout, primed, 1000 + j - 16);
      end
    end
    load_delay = 1'b0;
    vectors++;
    if (cur_delay !== DLY_W'(16)) begin
      miscompares++;
      $display("FAIL wrap_cur_delay: got %0d expected 16", cur_delay);
    end
  endtask

  // Primed at D=5, reload D=3 on sample 100.
  task automatic test_reload();
    for (int j = 0; j < 10; j++) begin
      load_delay = (j == 0); delay = DLY_W'(5);
      din = DW'(90 + j); din_valid = 1'b1;
      tick();
    end
    load_delay = 1'b0;
    vectors++;
    if (primed !== 1'b1 || dout !== DW'(94)) begin
      miscompares++;
      $display("FAIL reload_d5: dout=%0d primed=%b expected 94/1", dout, primed);
    end
    for (int j = 0; j < 7; j++) begin
      load_delay = (j == 0); delay = DLY_W'(3);
      din = DW'(100 + j);
      tick();
      vectors++;
      if (j < 3) begin
        if (primed !== 1'b0 || dout !== '0 || dout_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL reload_gap j=%0d: dout=%0d primed=%b expected 0/0", j, dout, primed);
        end
      end else if (primed !== 1'b1 || dout !== DW'(100 + j - 3)) begin
        miscompares++;
        $display("FAIL reload_d3 j=%0d: dout=%0d primed=%b expected %0d/1", j, dout, primed, 100 + j - 3);
      end
    end
    load_delay = 1'b0;
  endtask

  // Clamp 0 -> 1 and 31 -> 16; back-to-back loads, last one wins.
  task automatic test_clamp();
    load_delay = 1'b1; delay = DLY_W'(0);
    tick();
    vectors++;
    if (cur_delay !== DLY_W'(1)) begin
      miscompares++;
      $display("FAIL clamp_zero: got %0d expected 1", cur_delay);
    end
    delay = DLY_W'(31);
    tick();
    vectors++;
    if (cur_delay !== DLY_W'(16) || primed !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp_max: cur_delay=%0d primed=%b expected 16/0", cur_delay, primed);
    end
    delay = DLY_W'(2); din = DW'(77);
    tick();
    load_delay = 1'b0; din = DW'(78);
    tick();
    vectors++;
    if (cur_delay !== DLY_W'(2) || primed !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_fill: cur_delay=%0d primed=%b expected 2/0", cur_delay, primed);
    end
    din = DW'(79);
    tick();
    vectors++;
    if (primed !== 1'b1 || dout !== DW'(77)) begin
      miscompares++;
      $display("FAIL b2b_last_wins: dout=%0d primed=%b expected 77/1", dout, primed);
    end
  endtask

  // D=4, valid pattern 1,0,0,1 then 1s: bubbles reappear 4 cycles later.
  task automatic test_bubbles();
    logic [3:0] pat;
    pat = 4'b1001;
    for (int j = 0; j < 10; j++) begin
      load_delay = (j == 0); delay = DLY_W'(4);
      din = DW'(200 + j);
      din_valid = (j < 4) ? pat[3 - j] : 1'b1;
      tick();
      vectors++;
      if (j < 4) begin
        if (dout_valid !== 1'b0 || primed !== 1'b0) begin
          miscompares++;
          $display("FAIL bubble_fill j=%0d: dv=%b primed=%b expected 0/0", j, dout_valid, primed);
        end
      end else begin
        if (dout_valid !== ((j < 8) ? pat[7 - j] : 1'b1) || dout !== DW'(200 + j - 4)) begin
          miscompares++;
          $display("FAIL bubble_out j=%0d: dv=%b dout=%0d expected %b/%0d", j, dout_valid, dout,
                   (j < 8) ? pat[7 - j] : 1'b1, 200 + j - 4);
        end
      end
    end
    load_delay = 1'b0; din_valid = 1'b1;
  endtask

  // Asynchronous reset mid-stream at D=8; nothing from before reset may reappear.
  task automatic test_mid_reset();
    for (int j = 0; j < 12; j++) begin
      load_delay = (j == 0); delay = DLY_W'(8);
      din = DW'(300 + j);
      tick();
    end
    load_delay = 1'b0;
    vectors++;
    if (primed !== 1'b1 || dout !== DW'(303)) begin
      miscompares++;
      $display("FAIL midrst_pre: dout=%0d primed=%b expected 303/1", dout, primed);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (dout !== '0 || dout_valid !== 1'b0 || primed !== 1'b0 || cur_delay !== DLY_W'(1)) begin
      miscompares++;
      $display("FAIL midrst_async: dout=%0d dv=%b primed=%b cur=%0d expected 0/0/0/1",
               dout, dout_valid, primed, cur_delay);
    end
    din = DW'(399); load_delay = 1'b1;
    tick();
    vectors++;
    if (dout !== '0 || primed !== 1'b0 || cur_delay !== DLY_W'(1)) begin
      miscompares++;
      $display("FAIL midrst_hold: dout=%0d primed=%b cur=%0d expected 0/0/1", dout, primed, cur_delay);
    end
    rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      load_delay = (j == 0); delay = DLY_W'(8);
      din = DW'(500 + j);
      tick();
      vectors++;
      if (j < 8) begin
        if (dout !== '0 || primed !== 1'b0) begin
          miscompares++;
          $display("FAIL midrst_refill j=%0d: dout=%0d primed=%b expected 0/0", j, dout, primed);
        end
      end else if (dout !== DW'(500 + j - 8) || primed !== 1'b1) begin
        miscompares++;
        $display("FAIL midrst_data j=%0d: dout=%0d primed=%b expected %0d/1", j, dout, primed, 500 + j - 8);
      end
    end
    load_delay = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_wrap();
    test_reload();
    test_clamp();
    test_bubbles();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
